// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write counters for long-latency writers;
// stalls ID while a source or an over-issued destination still awaits its result.
module wb_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iss_valid,
    input  logic [4:0] iss_rd,
    input  logic       ret_valid,
    input  logic [4:0] ret_rd,
    input  logic       flush,
    input  logic [4:0] RS_ID,
    input  logic [4:0] RT_ID,
    input  logic       rs_used,
    input  logic       rt_used,
    input  logic       iss_req,
    output logic       stall_ID,
    output logic       busy,
    output logic       err
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] eff   [NREG];
    logic [NREG-1:0]  inc, dec;
    logic             err_q, err_d;

    // eff subtracts a same-cycle retire so the write-first register file releases the reader at once
    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            inc[r]   = iss_valid && iss_rd == 5'(r);
            dec[r]   = ret_valid && ret_rd == 5'(r) && cnt_q[r] != '0;
            eff[r]   = cnt_q[r] - (dec[r] ? ONE : '0);
            cnt_d[r] = (flush || r == 0) ? '0 :
                       (inc[r] && !dec[r] && cnt_q[r] != MAX) ? cnt_q[r] + ONE :
                       (dec[r] && !inc[r]) ? cnt_q[r] - ONE : cnt_q[r];
            busy     = busy | (cnt_q[r] != '0);
        end
        err_d = err_q | (ret_valid && ret_rd != '0 && cnt_q[ret_rd] == '0);
    end

    assign stall_ID = (rs_used && RS_ID != '0 && eff[RS_ID] != '0) ||
                      (rt_used && RT_ID != '0 && eff[RT_ID] != '0) ||
                      (iss_req && iss_rd != '0 && eff[iss_rd] == MAX);
    assign err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '{default: '0};
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: scenario tasks push expected stall/busy/err per cycle and pop them at the negedge.
module tb_wb_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       iss_valid, ret_valid, flush, rs_used, rt_used, iss_req;
    logic [4:0] iss_rd, ret_rd, RS_ID, RT_ID;
    logic       stall_ID, busy, err;

    typedef struct {
        logic stall;
        logic busy;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    wb_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .ret_valid(ret_valid), .ret_rd(ret_rd),
        .flush(flush),
        .RS_ID(RS_ID), .RT_ID(RT_ID),
        .rs_used(rs_used), .rt_used(rt_used),
        .iss_req(iss_req),
        .stall_ID(stall_ID), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic iv, input logic [4:0] ird, input logic rv, input logic [4:0] rrd,
                         input logic fl, input logic ru, input logic [4:0] rs, input logic tu,
                         input logic [4:0] rt, input logic rq);
        iss_valid = iv; iss_rd = ird; ret_valid = rv; ret_rd = rrd; flush = fl;
        rs_used = ru; RS_ID = rs; rt_used = tu; RT_ID = rt; iss_req = rq;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 5, 0, 0, 0, 1, 5, 0, 0, 0);
        exp_q.push_back('{1'b0, 1'b0, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        n_chk++; if (stall_ID !== e.stall) begin n_fail++; $display("FAIL reset_stall got %b exp %b", stall_ID, e.stall); end
        n_chk++; if (busy !== e.busy) begin n_fail++; $display("FAIL reset_busy got %b exp %b", busy, e.busy); end
        n_chk++; if (err !== e.err) begin n_fail++; $display("FAIL reset_err got %b exp %b", err, e.err); end
        @(posedge clk); #1;
    endtask

    task automatic test_raw();
        logic [7:0] iv = 8'b00000001, rv = 8'b01000000, ru = 8'b01111110;
        logic [7:0] st = 8'b00111110, bz = 8'b01111110;
        exp_t e;
        for (int c = 0; c < 8; c++) begin
            drive(iv[c], 8, rv[c], 8, 0, ru[c], 8, 0, 0, 0);
            exp_q.push_back('{st[c], bz[c], 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++; if (stall_ID !== e.stall) begin n_fail++; $display("FAIL raw_stall c=%0d got %b exp %b", c, stall_ID, e.stall); end
            n_chk++; if (busy !== e.busy) begin n_fail++; $display("FAIL raw_busy c=%0d got %b exp %b", c, busy, e.busy); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        logic [9:0] iv = 10'b0000000111, rq = 10'b0001011000, rv = 10'b0110010000, ru = 10'b0000100000;
        logic [9:0] st = 10'b0000101000, bz = 10'b0111111110;
        exp_t e;
        for (int c = 0; c < 10; c++) begin
            drive(iv[c], 3, rv[c], 3, 0, ru[c], 3, 0, 0, rq[c]);
            exp_q.push_back('{st[c], bz[c], 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++; if (stall_ID !== e.stall) begin n_fail++; $display("FAIL sat_stall c=%0d got %b exp %b", c, stall_ID, e.stall); end
            n_chk++; if (busy !== e.busy) begin n_fail++; $display("FAIL sat_busy c=%0d got %b exp %b", c, busy, e.busy); end
            n_chk++; if (err !== e.err) begin n_fail++; $display("FAIL sat_err c=%0d got %b exp %b", c, err, e.err); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] iv = 6'b010011, rv = 6'b001010, tu = 6'b001110, ru = 6'b110000, rq = 6'b010000;
        logic [5:0] st = 6'b000100, bz = 6'b001110;
        logic [4:0] rg;
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            rg = (c >= 4) ? 5'd0 : 5'd9;
            drive(iv[c], rg, rv[c], 9, 0, ru[c], rg, tu[c], 9, rq[c]);
            exp_q.push_back('{st[c], bz[c], 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++; if (stall_ID !== e.stall) begin n_fail++; $display("FAIL simul_stall c=%0d got %b exp %b", c, stall_ID, e.stall); end
            n_chk++; if (busy !== e.busy) begin n_fail++; $display("FAIL simul_busy c=%0d got %b exp %b", c, busy, e.busy); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_spurious();
        logic [5:0] iv = 6'b000100, rv = 6'b010001, ru = 6'b011010;
        logic [5:0] st = 6'b001000, bz = 6'b011000, er = 6'b111110;
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            drive(iv[c], 12, rv[c], 12, 0, ru[c], 12, 0, 0, 0);
            exp_q.push_back('{st[c], bz[c], er[c]});
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++; if (stall_ID !== e.stall) begin n_fail++; $display("FAIL spur_stall c=%0d got %b exp %b", c, stall_ID, e.stall); end
            n_chk++; if (busy !== e.busy) begin n_fail++; $display("FAIL spur_busy c=%0d got %b exp %b", c, busy, e.busy); end
            n_chk++; if (err !== e.err) begin n_fail++; $display("FAIL spur_err c=%0d got %b exp %b", c, err, e.err); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        logic [5:0] iv = 6'b001111, fl = 6'b001000, ru = 6'b111100, tu = 6'b010000;
        logic [5:0] st = 6'b001100, bz = 6'b001110;
        logic [4:0] ird, rs;
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            ird = (c < 2) ? 5'd4 : (c == 2) ? 5'd7 : 5'd10;
            rs  = (c == 5) ? 5'd7 : 5'd4;
            drive(iv[c], ird, 0, 0, fl[c], ru[c], rs, tu[c], 10, 0);
            exp_q.push_back('{st[c], bz[c], 1'b1});
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++; if (stall_ID !== e.stall) begin n_fail++; $display("FAIL flush_stall c=%0d got %b exp %b", c, stall_ID, e.stall); end
            n_chk++; if (busy !== e.busy) begin n_fail++; $display("FAIL flush_busy c=%0d got %b exp %b", c, busy, e.busy); end
            n_chk++; if (err !== e.err) begin n_fail++; $display("FAIL flush_err c=%0d got %b exp %b", c, err, e.err); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 20, 0, 0, 0, 1, 20, 0, 0, 0);
        exp_q.push_back('{1'b1, 1'b1, 1'b1});
        exp_q.push_back('{1'b0, 1'b0, 1'b0});
        #1;
        e = exp_q.pop_front();
        n_chk++; if (stall_ID !== e.stall) begin n_fail++; $display("FAIL arst_pre_stall got %b exp %b", stall_ID, e.stall); end
        n_chk++; if (busy !== e.busy) begin n_fail++; $display("FAIL arst_pre_busy got %b exp %b", busy, e.busy); end
        #1 rst_n = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_chk++; if (stall_ID !== e.stall) begin n_fail++; $display("FAIL arst_stall got %b exp %b", stall_ID, e.stall); end
        n_chk++; if (busy !== e.busy) begin n_fail++; $display("FAIL arst_busy got %b exp %b", busy, e.busy); end
        n_chk++; if (err !== e.err) begin n_fail++; $display("FAIL arst_err got %b exp %b", err, e.err); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_saturation();
        test_simultaneous();
        test_spurious();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Per-register pending-write scoreboard for the MIPS pipeline.
- Tracks destination registers of in-flight long-latency writers (mult/div unit results written to a GPR), from issue in ID until writeback.
- These results cannot be forwarded, so the block raises an ID-stage stall whenever an ID instruction reads, or over-issues, a register with outstanding writes.
- Sits beside the forwarding unit in ID/EX: the forwarding unit consumes results already produced; this block accounts for writes that are promised but not yet produced.

Parameters:
- NREG, 32, number of architectural registers tracked; index 0 is hardwired zero.
- CNT_W, 2, width of each per-register pending counter; max outstanding writes per register = 2^CNT_W - 1.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iss_valid  input  1  a long-latency writer is issuing from ID this cycle (already qualified by the pipeline with !stall).
- iss_rd  input  5  destination register of the issuing instruction.
- ret_valid  input  1  a long-latency result is writing back this cycle.
- ret_rd  input  5  destination register of the retiring write.
- flush  input  1  synchronous squash of all in-flight long-latency writers.
- RS_ID  input  5  source A of the instruction currently in ID.
- RT_ID  input  5  source B of the instruction currently in ID.
- rs_used  input  1  ID instruction actually reads RS_ID.
- rt_used  input  1  ID instruction actually reads RT_ID.
- iss_req  input  1  ID instruction is a long-latency writer; used for the saturation check.
- stall_ID  output  1  hold PC and IF/ID, inject bubble into EX.
- busy  output  1  at least one register has a nonzero pending count.
- err  output  1  sticky: retire seen for a register with zero pending count.

Behaviour:
- State: cnt[r], CNT_W bits, for r = 1..NREG-1. cnt[0] is constant 0; issue/retire to register 0 are ignored.
- Reset (rst_n low, asynchronous): every cnt[r] = 0, err = 0. Resulting outputs: stall_ID = 0, busy = 0.
- Effective count (combinational): eff[r] = cnt[r] - (ret_valid & ret_rd == r & cnt[r] != 0). A same-cycle retire releases the reader in that cycle, because writeback and register-file read are in the same cycle (write-first register file).
- stall_ID = (rs_used & RS_ID != 0 & eff[RS_ID] != 0) | (rt_used & RT_ID != 0 & eff[RT_ID] != 0) | (iss_req & iss_rd != 0 & eff[iss_rd] == 2^CNT_W - 1).
  - Purely combinational; no latency.
  - The third term prevents counter overflow.
- Counter update at clock edge, for each r != 0:
  - inc = iss_valid & iss_rd == r.
  - dec = ret_valid & ret_rd == r & cnt[r] != 0.
  - inc & !dec: +1. dec & !inc: -1. Both or neither: unchanged.
  - The counter never wraps. An issue at max is prevented by stall_ID; if iss_valid is asserted anyway, cnt saturates at max.
- err: set on any clock edge where ret_valid & ret_rd != 0 & cnt[ret_rd] == 0. The count stays 0. Cleared only by reset.
- flush: on the clock edge, all cnt = 0, and any same-cycle issue or retire is discarded.
  - err is still evaluated that cycle.
  - The flush does not affect combinational stall_ID in the flush cycle.
- busy = OR over r of (cnt[r] != 0), taken from registered counts, not eff.
- Retires are in order per register (single long-latency unit); the scoreboard only counts and does not track order.
- Reset mid-operation: all counts drop immediately, asynchronously. stall_ID and busy fall in the same cycle without waiting for a clock.

Test Plan:
- Reset: hold rst_n=0 with iss_valid=1, iss_rd=5 for 3 cycles, release. Required: busy=0, err=0, stall_ID=0 with rs_used=1, RS_ID=5.
- Basic RAW: issue rd=8 at cycle 0, retire rd=8 at cycle 6; ID reads RS_ID=8 (rs_used=1) cycles 1-6. Required: stall_ID=1 cycles 1-5, 0 at cycle 6 (same-cycle release), busy=0 from cycle 7.
- Saturation: issue rd=3 three times with no retire. Then iss_req=1, iss_rd=3. Required: stall_ID=1 and cnt[3]=3. One retire of 3 drops stall_ID the same cycle, and the count returns to 2.
- Simultaneous issue and retire to rd=9 with cnt[9]=1. Required: cnt[9] stays 1 and RT_ID=9 with rt_used=1 keeps stall_ID=1. Register 0 writes: issue rd=0 leaves busy=0, and RS_ID=0 never stalls.
- Spurious retire rd=12 with cnt[12]=0. Required: err=1 next cycle and sticky through later traffic; cnt[12]=0.
- Flush with counts at r4=2, r7=1 plus a same-cycle issue to r10. Required: after the edge all counts are 0 (including r10) and busy=0. Asynchronous reset pulse mid-run clears busy without a clock edge.
